// File: rtl/fpmul_pkg.sv
// Shared definitions for the pipelined sign/exponent/mantissa multiplier:
// special-value encodings, flag bit positions and rounding-mode codes.
package fpmul_pkg;

    localparam int FLAG_NAN = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;
    localparam int NB_FLAGS = 3;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Encodings are built wide and sliced by the user to its own word width.
    function automatic logic [63:0] enc_nan(input int nb_exp, input int nb_man);
        logic [63:0] one;
        one = 64'd1;
        return (one << (nb_exp + nb_man)) | (((one << nb_exp) - one) << nb_man) | (one << (nb_man - 1));
    endfunction

    function automatic logic [63:0] enc_inf(input int nb_exp, input int nb_man);
        logic [63:0] one;
        one = 64'd1;
        return ((one << nb_exp) - one) << nb_man;
    endfunction

    function automatic logic [63:0] enc_zero(input int nb_exp, input int nb_man, input int bias);
        logic [63:0] b;
        b = 64'(bias);
        return (b & ((64'd1 << nb_exp) - 64'd1)) << nb_man;
    endfunction

endpackage

// File: rtl/fpmul_pipe_if.sv
// Operand/result handshake bundle of fpmul_pipe; the slave side is the multiplier.
interface fpmul_pipe_if #(
    parameter int NB_DATA = 13
);
    logic [NB_DATA-1:0] i_data1;
    logic [NB_DATA-1:0] i_data2;
    logic               i_valid;
    logic               o_ready;
    logic               i_rnd_mode;
    logic [NB_DATA-1:0] o_mul;
    logic [2:0]         o_flags;
    logic               o_valid;
    logic               i_ready;

    modport slave (
        input  i_data1, i_data2, i_valid, i_rnd_mode, i_ready,
        output o_ready, o_mul, o_flags, o_valid
    );

    modport master (
        output i_data1, i_data2, i_valid, i_rnd_mode, i_ready,
        input  o_ready, o_mul, o_flags, o_valid
    );
endinterface

// File: rtl/fpmul_pipe_classify.sv
// Combinational decode of one operand into nan / inf / zero classes.
module fp_classify
    import fpmul_pkg::*;
#(
    parameter int NB_EXP = 4,
    parameter int NB_MAN = 8
) (
    input  logic [NB_EXP-1:0] i_exp,
    input  logic [NB_MAN-1:0] i_man,
    output fp_class_t         o_class
);
    // Special values are keyed on an all-ones exponent; zero needs a finite exponent.
    always_comb begin
        o_class      = '0;
        o_class.nan  = (&i_exp) & (|i_man);
        o_class.inf  = (&i_exp) & ~(|i_man);
        o_class.zero = ~(&i_exp) & ~(|i_man);
    end
endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined floating-point multiplier with truncate/round-half-up
// rounding, exception flags and a fully back-pressured valid/ready handshake.
module fpmul_pipe
    import fpmul_pkg::*;
#(
    parameter int NB_EXP  = 4,
    parameter int NB_MAN  = 8,
    parameter int BIAS    = 2**(NB_EXP-1)-1,
    parameter int NB_DATA = 1+NB_EXP+NB_MAN
) (
    input logic         clock,
    input logic         i_reset,
    fpmul_pipe_if.slave bus
);
    localparam int NB_E = NB_EXP + 2;
    // Only the product bits that either alignment can select are carried past S2.
    localparam int NB_P = NB_MAN + 2;

    localparam logic [NB_DATA-1:0] NAN_W    = NB_DATA'(enc_nan(NB_EXP, NB_MAN));
    localparam logic [NB_DATA-2:0] INF_MAG  = (NB_DATA-1)'(enc_inf(NB_EXP, NB_MAN));
    localparam logic [NB_DATA-2:0] ZERO_MAG = (NB_DATA-1)'(enc_zero(NB_EXP, NB_MAN, BIAS));
    localparam logic [NB_E-1:0]    E_ONE    = {{(NB_E-1){1'b0}}, 1'b1};
    localparam logic [NB_E-1:0]    E_BIAS   = NB_E'(BIAS);
    localparam logic [NB_E-1:0]    E_MAX    = {2'b00, {NB_EXP{1'b1}}};

    typedef struct packed {
        logic              valid;
        logic              sign_a;
        logic [NB_EXP-1:0] exp_a;
        logic [NB_MAN-1:0] man_a;
        logic              sign_b;
        logic [NB_EXP-1:0] exp_b;
        logic [NB_MAN-1:0] man_b;
        fp_class_t         cls_a;
        fp_class_t         cls_b;
        logic              rnd;
    } s1_t;

    typedef struct packed {
        logic            valid;
        logic            sign;
        logic            nan;
        logic            inf;
        logic            zero;
        logic            rnd;
        logic [NB_E-1:0] exp;
        logic [NB_P-1:0] prod;
    } s2_t;

    typedef struct packed {
        logic                valid;
        logic [NB_DATA-1:0]  mul;
        logic [NB_FLAGS-1:0] flags;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic                adv_s;
    fp_class_t           cls_a_s;
    fp_class_t           cls_b_s;
    logic [NB_MAN-1:0]   man_s;
    logic                rbit_s;
    logic [NB_E-1:0]     exp_s;
    logic [NB_MAN:0]     man_rnd_s;
    logic [NB_MAN-1:0]   man_fin_s;
    logic [NB_DATA-1:0]  res_mul_s;
    logic [NB_FLAGS-1:0] res_flags_s;

    fp_classify #(.NB_EXP(NB_EXP), .NB_MAN(NB_MAN)) u_cls_a (
        .i_exp   (bus.i_data1[NB_DATA-2:NB_MAN]),
        .i_man   (bus.i_data1[NB_MAN-1:0]),
        .o_class (cls_a_s)
    );

    fp_classify #(.NB_EXP(NB_EXP), .NB_MAN(NB_MAN)) u_cls_b (
        .i_exp   (bus.i_data2[NB_DATA-2:NB_MAN]),
        .i_man   (bus.i_data2[NB_MAN-1:0]),
        .o_class (cls_b_s)
    );

    // Whole pipe advances unless a result is parked at the output.
    always_comb begin
        adv_s       = ~s3_q.valid | bus.i_ready;
        bus.o_ready = adv_s;
        bus.o_valid = s3_q.valid;
        bus.o_mul   = s3_q.mul;
        bus.o_flags = s3_q.flags;
    end

    // S1: capture operands with their classes and the rounding mode.
    always_comb begin
        s1_d = s1_q;
        if (adv_s) begin
            s1_d.valid = bus.i_valid;
            if (bus.i_valid) begin
                s1_d.sign_a = bus.i_data1[NB_DATA-1];
                s1_d.exp_a  = bus.i_data1[NB_DATA-2:NB_MAN];
                s1_d.man_a  = bus.i_data1[NB_MAN-1:0];
                s1_d.sign_b = bus.i_data2[NB_DATA-1];
                s1_d.exp_b  = bus.i_data2[NB_DATA-2:NB_MAN];
                s1_d.man_b  = bus.i_data2[NB_MAN-1:0];
                s1_d.cls_a  = cls_a_s;
                s1_d.cls_b  = cls_b_s;
                s1_d.rnd    = bus.i_rnd_mode;
            end else begin
                s1_d.rnd = s1_q.rnd;
            end
        end else begin
            s1_d = s1_q;
        end
    end

    // S2: sign, de-biased exponent, mantissa product and merged exception classes.
    always_comb begin
        s2_d = s2_q;
        if (adv_s) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.sign = s1_q.sign_a ^ s1_q.sign_b;
                s2_d.nan  = s1_q.cls_a.nan | s1_q.cls_b.nan
                          | (s1_q.cls_a.inf & s1_q.cls_b.zero)
                          | (s1_q.cls_a.zero & s1_q.cls_b.inf);
                s2_d.inf  = s1_q.cls_a.inf | s1_q.cls_b.inf;
                s2_d.zero = s1_q.cls_a.zero | s1_q.cls_b.zero;
                s2_d.rnd  = s1_q.rnd;
                s2_d.exp  = {2'b00, s1_q.exp_a} + {2'b00, s1_q.exp_b} - E_BIAS;
                s2_d.prod = NB_P'(({{NB_MAN{1'b0}}, s1_q.man_a} * {{NB_MAN{1'b0}}, s1_q.man_b}) >> (NB_MAN - 2));
            end else begin
                s2_d.rnd = s2_q.rnd;
            end
        end else begin
            s2_d = s2_q;
        end
    end

    // S3 datapath: one-step right normalisation, rounding, then exception priority.
    always_comb begin
        man_s       = '0;
        rbit_s      = 1'b0;
        exp_s       = s2_q.exp;
        man_rnd_s   = '0;
        man_fin_s   = '0;
        res_mul_s   = '0;
        res_flags_s = 3'b000;
        if (s2_q.prod[NB_P-1]) begin
            man_s  = s2_q.prod[NB_P-1:2];
            rbit_s = s2_q.prod[1];
            exp_s  = s2_q.exp + E_ONE;
        end else begin
            man_s  = s2_q.prod[NB_P-2:1];
            rbit_s = s2_q.prod[0];
            exp_s  = s2_q.exp;
        end
        man_rnd_s = {1'b0, man_s} + {{NB_MAN{1'b0}}, (s2_q.rnd == RND_HALF_UP) & rbit_s};
        if (man_rnd_s[NB_MAN]) begin
            man_fin_s = {1'b1, {(NB_MAN-1){1'b0}}};
            exp_s     = exp_s + E_ONE;
        end else begin
            man_fin_s = man_rnd_s[NB_MAN-1:0];
        end
        if (s2_q.nan) begin
            res_mul_s             = NAN_W;
            res_flags_s[FLAG_NAN] = 1'b1;
        end else if (s2_q.inf) begin
            res_mul_s = {s2_q.sign, INF_MAG};
        end else if (s2_q.zero) begin
            res_mul_s = {s2_q.sign, ZERO_MAG};
        end else if (!exp_s[NB_E-1] && (exp_s >= E_MAX)) begin
            res_mul_s             = {s2_q.sign, INF_MAG};
            res_flags_s[FLAG_OVF] = 1'b1;
        end else if (exp_s[NB_E-1]) begin
            res_mul_s             = {s2_q.sign, ZERO_MAG};
            res_flags_s[FLAG_UNF] = 1'b1;
        end else begin
            res_mul_s = {s2_q.sign, exp_s[NB_EXP-1:0], man_fin_s};
        end
    end

    // S3 register update: result loads only when the pipe moves and S2 holds data.
    always_comb begin
        s3_d = s3_q;
        if (adv_s) begin
            s3_d.valid = s2_q.valid;
            if (s2_q.valid) begin
                s3_d.mul   = res_mul_s;
                s3_d.flags = res_flags_s;
            end else begin
                s3_d.mul   = s3_q.mul;
                s3_d.flags = s3_q.flags;
            end
        end else begin
            s3_d = s3_q;
        end
    end

    // Stage registers; reset flushes everything including a stalled result.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe: directed vectors, backpressure, reset flush
// and a random stream against an integer reference model.
module tb_fpmul_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpmul_pipe_if #(.NB_DATA(13)) bus();

    fpmul_pipe dut (
        .clock   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [12:0] a;
        logic [12:0] b;
        logic        rnd;
        logic [15:0] ev;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          accepts = 0;
    int          rdy_mode = 1;
    logic [15:0] sb[$];
    vec_t        vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [12:0] a, input logic [12:0] b, input logic rnd);
        int ea, eb, ma, mb, p, e, m, r;
        logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [31:0] ev, mv;
        ea = int'(a[11:8]); eb = int'(b[11:8]);
        ma = int'(a[7:0]);  mb = int'(b[7:0]);
        s = a[12] ^ b[12];
        nan_a = (ea == 15) && (ma != 0);  nan_b = (eb == 15) && (mb != 0);
        inf_a = (ea == 15) && (ma == 0);  inf_b = (eb == 15) && (mb == 0);
        zero_a = (ea != 15) && (ma == 0); zero_b = (eb != 15) && (mb == 0);
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return {3'b100, 13'h1F80};
        if (inf_a || inf_b) return {3'b000, s, 4'hF, 8'h00};
        if (zero_a || zero_b) return {3'b000, s, 4'h7, 8'h00};
        p = ma * mb;
        e = ea + eb - 7;
        if (p >= 32768) begin
            m = p / 256; r = (p / 128) % 2; e = e + 1;
        end else begin
            m = p / 128; r = (p / 64) % 2;
        end
        if (rnd && (r == 1)) m = m + 1;
        if (m == 256) begin
            m = 128; e = e + 1;
        end
        if (e >= 15) return {3'b010, s, 4'hF, 8'h00};
        if (e < 0) return {3'b001, s, 4'h7, 8'h00};
        ev = 32'(e); mv = 32'(m);
        return {3'b000, s, ev[3:0], mv[7:0]};
    endfunction

    function automatic logic [12:0] rand_op();
        logic [12:0] v;
        v = 13'($urandom);
        v[11:8] = 4'($urandom_range(2, 12));
        v[7] = 1'b1;
        if ($urandom_range(0, 9) == 0) v[11:8] = 4'hF;
        if ($urandom_range(0, 9) == 0) v[7:0] = 8'h00;
        return v;
    endfunction

    task automatic add_vec(input logic [12:0] a, input logic [12:0] b, input logic r,
                           input logic [2:0] f, input logic [12:0] m);
        vq.push_back({a, b, r, f, m});
    endtask

    task automatic send(input logic [12:0] a, input logic [12:0] b, input logic r,
                        input logic [15:0] ev, input bit push);
        int waits;
        waits = 0;
        @(negedge clk);
        bus.i_data1 = a; bus.i_data2 = b; bus.i_rnd_mode = r; bus.i_valid = 1'b1;
        #2;
        while (!bus.o_ready && waits < 200) begin
            @(negedge clk); #2; waits++;
        end
        if (!bus.o_ready) begin
            check("accept_timeout", 32'(bus.o_ready), 32'd1);
        end else if (push) begin
            sb.push_back(ev);
            accepts++;
        end else begin
            accepts++;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk); w++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Downstream readiness: always, never, or random per cycle.
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.i_ready = 1'b0;
                1:       bus.i_ready = 1'b1;
                default: bus.i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: output stability while stalled, and in-order scoreboard compare.
    logic        prev_stall = 1'b0;
    logic [12:0] prev_mul;
    logic [2:0]  prev_flags;
    logic [15:0] exp_v;
    initial begin
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.o_valid), 32'd1);
                    check("hold_mul", 32'(bus.o_mul), 32'(prev_mul));
                    check("hold_flags", 32'(bus.o_flags), 32'(prev_flags));
                end
                if (bus.o_valid && bus.i_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(bus.o_mul), 32'hFFFF_FFFF);
                    end else begin
                        exp_v = sb.pop_front();
                        check("o_mul", 32'(bus.o_mul), 32'(exp_v[12:0]));
                        check("o_flags", 32'(bus.o_flags), 32'(exp_v[15:13]));
                    end
                end
                prev_stall = bus.o_valid && !bus.i_ready;
                prev_mul   = bus.o_mul;
                prev_flags = bus.o_flags;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat;
        logic [12:0] ra, rb;
        logic        rr;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_data1 = 13'h0000; bus.i_data2 = 13'h0000; bus.i_rnd_mode = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_valid", 32'(bus.o_valid), 32'd0);
        check("reset_mul", 32'(bus.o_mul), 32'd0);
        check("reset_flags", 32'(bus.o_flags), 32'd0);
        check("reset_ready", 32'(bus.o_ready), 32'd1);

        add_vec(13'h0780, 13'h0880, 1'b1, 3'b000, 13'h0880);
        add_vec(13'h07C1, 13'h07C1, 1'b1, 3'b000, 13'h0892);
        add_vec(13'h07C1, 13'h07C1, 1'b0, 3'b000, 13'h0891);
        add_vec(13'h07C0, 13'h07C0, 1'b1, 3'b000, 13'h0890);
        add_vec(13'h1E80, 13'h0E80, 1'b1, 3'b010, 13'h1F00);
        add_vec(13'h0080, 13'h0080, 1'b1, 3'b001, 13'h0700);
        add_vec(13'h0F00, 13'h0700, 1'b1, 3'b100, 13'h1F80);
        add_vec(13'h1F80, 13'h0780, 1'b1, 3'b100, 13'h1F80);
        add_vec(13'h07B5, 13'h07B5, 1'b1, 3'b000, 13'h0880);
        add_vec(13'h07B5, 13'h07B5, 1'b0, 3'b000, 13'h07FF);
        add_vec(13'h0E80, 13'h0780, 1'b1, 3'b000, 13'h0E80);
        add_vec(13'h0E80, 13'h0880, 1'b1, 3'b010, 13'h0F00);
        add_vec(13'h0080, 13'h0780, 1'b1, 3'b000, 13'h0080);
        add_vec(13'h1700, 13'h0780, 1'b1, 3'b000, 13'h1700);
        add_vec(13'h0F00, 13'h1780, 1'b1, 3'b000, 13'h1F00);
        add_vec(13'h1780, 13'h0880, 1'b1, 3'b000, 13'h1880);
        foreach (vq[i]) send(vq[i].a, vq[i].b, vq[i].rnd, vq[i].ev, 1'b1);
        drain();

        // Five pairs against a blocked output for six cycles.
        rdy_mode = 0;
        base = accepts;
        fork
            begin
                send(13'h0780, 13'h0880, 1'b1, {3'b000, 13'h0880}, 1'b1);
                send(13'h07C1, 13'h07C1, 1'b1, {3'b000, 13'h0892}, 1'b1);
                send(13'h07C0, 13'h07C0, 1'b1, {3'b000, 13'h0890}, 1'b1);
                send(13'h0E80, 13'h0780, 1'b1, {3'b000, 13'h0E80}, 1'b1);
                send(13'h1780, 13'h0880, 1'b1, {3'b000, 13'h1880}, 1'b1);
            end
            begin
                repeat (6) @(negedge clk);
                #3;
                check("bp_accepts", 32'(accepts - base), 32'd3);
                check("bp_ready", 32'(bus.o_ready), 32'd0);
                check("bp_valid", 32'(bus.o_valid), 32'd1);
                check("bp_first", 32'(bus.o_mul), 32'h0880);
                rdy_mode = 1;
            end
        join
        drain();

        // Fill and stall the pipe, then reset it away.
        rdy_mode = 0;
        send(13'h0780, 13'h0780, 1'b1, 16'h0000, 1'b0);
        send(13'h0880, 13'h0880, 1'b1, 16'h0000, 1'b0);
        send(13'h0980, 13'h0980, 1'b1, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        check("stall_full_valid", 32'(bus.o_valid), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #2;
        check("rst_flush_valid", 32'(bus.o_valid), 32'd0);
        check("rst_flush_mul", 32'(bus.o_mul), 32'd0);
        check("rst_flush_ready", 32'(bus.o_ready), 32'd1);
        rdy_mode = 1;
        send(13'h07C1, 13'h07C1, 1'b1, {3'b000, 13'h0892}, 1'b1);
        lat = 0;
        while (!bus.o_valid && lat < 10) begin
            @(negedge clk); #2; lat++;
        end
        check("post_rst_latency", 32'(lat), 32'd3);
        drain();

        // Random operands, random gaps, random downstream readiness.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            ra = rand_op();
            rb = rand_op();
            rr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(ra, rb, rr, model(ra, rb, rr), 1'b1);
        end
        rdy_mode = 1;
        drain();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
